// File: rtl/ddr3_seq_pkg.sv
// ddr3_seq_pkg: shared state encoding, MIG command codes and default widths for the burst sequencer
package ddr3_seq_pkg;
    localparam int DEF_ADDR_W          = 29;
    localparam int DEF_DATA_W          = 256;
    localparam int DEF_CNT_W           = 16;
    localparam int DEF_ADDR_INC        = 8;
    localparam int DEF_MAX_OUTSTANDING = 32;
    localparam int DEF_RDF_CNT_W       = 10;
    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
endpackage

// File: rtl/ddr3_rd_credit.sv
// ddr3_rd_credit: counts issued read commands and returned beats, grants credit against the read FIFO space
module ddr3_rd_credit
    import ddr3_seq_pkg::*;
#(
    parameter int CNT_W           = DEF_CNT_W,
    parameter int RDF_CNT_W       = DEF_RDF_CNT_W,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                 clk,
    input  logic                 sys_rst,
    input  logic                 clear,
    input  logic                 issue,
    input  logic                 ret,
    input  logic [RDF_CNT_W-1:0] rfifo_free,
    output logic [CNT_W-1:0]     issued,
    output logic [CNT_W-1:0]     returned,
    output logic                 credit_ok
);
    logic [CNT_W-1:0] outstanding;

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            issued   <= '0;
            returned <= '0;
        end else if (clear) begin
            issued   <= '0;
            returned <= '0;
        end else begin
            if (issue) issued <= issued + 1'b1;
            if (ret) returned <= returned + 1'b1;
        end
    end

    assign outstanding = issued - returned;
    assign credit_ok   = 32'(outstanding) < 32'(MAX_OUTSTANDING) && 32'(outstanding) < 32'(rfifo_free);
endmodule

// File: rtl/ddr3_burst_sequencer.sv
// ddr3_burst_sequencer: moves FIFO beats to and from the MIG app interface as single-beat write/read jobs
module ddr3_burst_sequencer
    import ddr3_seq_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int ADDR_INC        = DEF_ADDR_INC,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int RDF_CNT_W       = DEF_RDF_CNT_W
) (
    input  logic                 clk,
    input  logic                 sys_rst,
    input  logic                 init_calib_complete,
    input  logic [ADDR_W-1:0]    wr_base,
    input  logic [CNT_W-1:0]     wr_cnt,
    input  logic                 start_write,
    input  logic [ADDR_W-1:0]    rd_base,
    input  logic [CNT_W-1:0]     rd_cnt,
    input  logic                 start_read,
    output logic                 busy,
    output logic                 wr_done,
    output logic                 rd_done,
    output logic                 start_reject,
    input  logic                 wfifo_empty,
    input  logic [DATA_W-1:0]    wfifo_dout,
    output logic                 wfifo_rd_en,
    input  logic [RDF_CNT_W-1:0] rfifo_free,
    output logic [DATA_W-1:0]    rfifo_din,
    output logic                 rfifo_wr_en,
    output logic [ADDR_W-1:0]    app_addr,
    output logic [2:0]           app_cmd,
    output logic                 app_en,
    input  logic                 app_rdy,
    output logic [DATA_W-1:0]    app_wdf_data,
    output logic                 app_wdf_wren,
    output logic                 app_wdf_end,
    input  logic                 app_wdf_rdy,
    input  logic [DATA_W-1:0]    app_rd_data,
    input  logic                 app_rd_data_valid
);
    state_t           state;
    logic [CNT_W-1:0] cnt, data_sent, cmd_sent, issued, returned;
    logic             credit_ok, cmd_accept;

    ddr3_rd_credit #(
        .CNT_W(CNT_W),
        .RDF_CNT_W(RDF_CNT_W),
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_credit (
        .clk(clk),
        .sys_rst(sys_rst),
        .clear(state == IDLE),
        .issue(state == READ && cmd_accept),
        .ret(state == READ && app_rd_data_valid),
        .rfifo_free(rfifo_free),
        .issued(issued),
        .returned(returned),
        .credit_ok(credit_ok)
    );

    assign busy         = state != IDLE;
    assign app_wdf_wren = state == WRITE && !wfifo_empty && data_sent < cnt;
    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_data = app_wdf_wren ? wfifo_dout : '0;
    assign wfifo_rd_en  = app_wdf_wren && app_wdf_rdy;
    // a write command only follows a beat already handed to the MIG
    assign app_en       = (state == WRITE) ? (cmd_sent < data_sent) : (state == READ && issued < cnt && credit_ok);
    assign cmd_accept   = app_en && app_rdy;

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            data_sent    <= '0;
            cmd_sent     <= '0;
            app_addr     <= '0;
            app_cmd      <= CMD_WRITE;
            wr_done      <= 1'b0;
            rd_done      <= 1'b0;
            start_reject <= 1'b0;
            rfifo_din    <= '0;
            rfifo_wr_en  <= 1'b0;
        end else begin
            wr_done      <= 1'b0;
            start_reject <= (start_write || start_read) && (state != IDLE || !init_calib_complete || (start_write && start_read));
            rfifo_din    <= app_rd_data;
            rfifo_wr_en  <= app_rd_data_valid && state == READ;
            if (cmd_accept) app_addr <= app_addr + ADDR_W'(ADDR_INC);
            case (state)
                IDLE: begin
                    rd_done <= 1'b0;
                    if (init_calib_complete && start_write) begin
                        cnt       <= wr_cnt;
                        app_addr  <= wr_base;
                        app_cmd   <= CMD_WRITE;
                        data_sent <= '0;
                        cmd_sent  <= '0;
                        if (wr_cnt == '0) wr_done <= 1'b1;
                        else state <= WRITE;
                    end else if (init_calib_complete && start_read) begin
                        cnt      <= rd_cnt;
                        app_addr <= rd_base;
                        app_cmd  <= CMD_READ;
                        if (rd_cnt == '0) rd_done <= 1'b1;
                        else state <= READ;
                    end
                end
                WRITE: begin
                    if (wfifo_rd_en) data_sent <= data_sent + 1'b1;
                    if (cmd_accept) cmd_sent <= cmd_sent + 1'b1;
                    if (cmd_accept && cmd_sent + 1'b1 == cnt) wr_done <= 1'b1;
                    if (cmd_sent == cnt) state <= IDLE;
                end
                READ: begin
                    rd_done <= returned == cnt && !rd_done;
                    if (rd_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr3_burst_sequencer.sv
// tb_ddr3_burst_sequencer: directed write, read, credit, reject, wrap and reset scenarios against FIFO/MIG models
module tb_ddr3_burst_sequencer;
    import ddr3_seq_pkg::*;
    localparam int RET_LAT = 10;
    typedef struct {int due; logic [255:0] data;} ret_t;

    logic         clk = 1'b0;
    logic         sys_rst, init_calib_complete, start_write, start_read;
    logic [28:0]  wr_base, rd_base, app_addr;
    logic [15:0]  wr_cnt, rd_cnt;
    logic         busy, wr_done, rd_done, start_reject;
    logic         wfifo_empty, wfifo_rd_en, rfifo_wr_en;
    logic [255:0] wfifo_dout, rfifo_din, app_wdf_data, app_rd_data;
    logic [9:0]   rfifo_free;
    logic [2:0]   app_cmd;
    logic         app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy, app_rd_data_valid;

    always #5 clk = ~clk;

    ddr3_burst_sequencer dut (
        .clk(clk), .sys_rst(sys_rst), .init_calib_complete(init_calib_complete),
        .wr_base(wr_base), .wr_cnt(wr_cnt), .start_write(start_write),
        .rd_base(rd_base), .rd_cnt(rd_cnt), .start_read(start_read),
        .busy(busy), .wr_done(wr_done), .rd_done(rd_done), .start_reject(start_reject),
        .wfifo_empty(wfifo_empty), .wfifo_dout(wfifo_dout), .wfifo_rd_en(wfifo_rd_en),
        .rfifo_free(rfifo_free), .rfifo_din(rfifo_din), .rfifo_wr_en(rfifo_wr_en),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
    );

    logic [255:0] wfifo_q[$], wdf_q[$], rx_q[$];
    logic [28:0]  cmd_q[$];
    ret_t         ret_q[$];
    int           cyc, pops, issued, returned, max_out, lat_bad, wr_dones, rd_dones;
    int           wr_done_cyc, rd_done_cyc, last_cmd_cyc, last_rx_cyc;
    logic         busy_at_wdone, busy_at_rdone, prev_valid, pop_now;
    logic [255:0] prev_data;
    int           checks, failures;

    function automatic logic [255:0] wdat(input int i);
        return {8{32'hC0DE0000 + 32'(i)}};
    endfunction

    function automatic logic [255:0] rdata(input logic [28:0] a);
        return {8{3'b101, a}};
    endfunction

    function automatic logic [28:0] qa(input int i);
        return i < cmd_q.size() ? cmd_q[i] : '1;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_w(input logic [255:0] d);
        wfifo_q.push_back(d);
        wfifo_empty = 1'b0;
        wfifo_dout  = wfifo_q[0];
    endtask

    task automatic clear_logs();
        wdf_q.delete(); rx_q.delete(); cmd_q.delete();
        pops = 0; issued = 0; returned = 0; max_out = 0; lat_bad = 0; wr_dones = 0; rd_dones = 0;
    endtask

    task automatic start_wr(input logic [28:0] base, input logic [15:0] n);
        tick(1);
        wr_base = base; wr_cnt = n; start_write = 1'b1;
        tick(1);
        start_write = 1'b0;
    endtask

    task automatic start_rd(input logic [28:0] base, input logic [15:0] n);
        tick(1);
        rd_base = base; rd_cnt = n; start_read = 1'b1;
        tick(1);
        start_read = 1'b0;
    endtask

    task automatic wait_done(input bit rd, input int budget, input string tag);
        int n0;
        bit seen;
        n0 = rd ? rd_dones : wr_dones;
        seen = 1'b0;
        for (int t = 0; t < budget && !seen; t++) begin
            @(negedge clk);
            seen = (rd ? rd_dones : wr_dones) != n0;
        end
        check(tag, seen, 1'b1);
        tick(2);
    endtask

    // FIFO / MIG model: observe handshakes mid-cycle, apply their effects just after the edge
    initial begin
        forever begin
            @(negedge clk);
            if (rfifo_wr_en) begin
                if (!prev_valid || rfifo_din !== prev_data) lat_bad++;
                rx_q.push_back(rfifo_din);
                last_rx_cyc = cyc;
            end
            prev_valid = app_rd_data_valid;
            prev_data  = app_rd_data;
            if (app_wdf_wren && app_wdf_rdy) wdf_q.push_back(app_wdf_data);
            if (wfifo_rd_en) pops++;
            if (app_en && app_rdy) begin
                cmd_q.push_back(app_addr);
                last_cmd_cyc = cyc;
                if (app_cmd == CMD_READ) begin
                    ret_q.push_back('{due: cyc + RET_LAT, data: rdata(app_addr)});
                    issued++;
                end
            end
            if (app_rd_data_valid) returned++;
            if (issued - returned > max_out) max_out = issued - returned;
            if (wr_done) begin wr_dones++; wr_done_cyc = cyc; busy_at_wdone = busy; end
            if (rd_done) begin rd_dones++; rd_done_cyc = cyc; busy_at_rdone = busy; end
            pop_now = wfifo_rd_en;
            @(posedge clk);
            #1;
            cyc++;
            if (pop_now && wfifo_q.size() > 0) wfifo_q.delete(0);
            wfifo_empty = wfifo_q.size() == 0;
            wfifo_dout  = wfifo_q.size() == 0 ? '0 : wfifo_q[0];
            if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
                app_rd_data_valid = 1'b1;
                app_rd_data       = ret_q[0].data;
                ret_q.delete(0);
            end else begin
                app_rd_data_valid = 1'b0;
                app_rd_data       = '0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, snap_rx, snap_rd, snap_ret;
        sys_rst = 1'b0; init_calib_complete = 1'b1; start_write = 1'b0; start_read = 1'b0;
        wr_base = '0; rd_base = '0; wr_cnt = '0; rd_cnt = '0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; rfifo_free = 10'd16;
        app_rd_data_valid = 1'b0; app_rd_data = '0; wfifo_empty = 1'b1; wfifo_dout = '0;
        push_w(256'hDEAD_BEEF);
        repeat (3) @(negedge clk);
        check("rst_ctrl", {busy, wr_done, rd_done, start_reject, wfifo_rd_en, rfifo_wr_en, app_en, app_wdf_wren, app_wdf_end}, '0);
        check("rst_addr", app_addr, '0);
        check("rst_cmd", app_cmd, 3'b000);
        check("rst_data", |{app_wdf_data, rfifo_din}, 1'b0);
        tick(1);
        wfifo_q.delete(); wfifo_empty = 1'b1; wfifo_dout = '0;
        sys_rst = 1'b1;
        tick(2);

        // four-beat write, both MIG ports always ready
        clear_logs();
        for (int i = 0; i < 4; i++) push_w(wdat(i));
        start_wr(29'h100, 16'd4);
        @(negedge clk);
        check("t1_wren_lat", app_wdf_wren, 1'b1);
        check("t1_head", app_wdf_data == wdat(0), 1'b1);
        check("t1_busy", busy, 1'b1);
        wait_done(1'b0, 50, "t1_done_seen");
        bad = 0;
        for (int i = 0; i < 4; i++) if (i >= wdf_q.size() || wdf_q[i] !== wdat(i)) bad++;
        check("t1_wdata", bad, 0);
        check("t1_ncmd", cmd_q.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("t1_addr%0d", i), qa(i), 29'h100 + 29'(8 * i));
        check("t1_pops", pops, 4);
        check("t1_done_lat", wr_done_cyc - last_cmd_cyc, 1);
        check("t1_busy_at_done", busy_at_wdone, 1'b1);
        check("t1_busy_after", busy, 1'b0);
        check("t1_ndone", wr_dones, 1);

        // three-beat write with the command port stalled after the first beat
        clear_logs();
        for (int i = 0; i < 3; i++) push_w(wdat(10 + i));
        tick(1);
        app_rdy = 1'b0;
        start_wr(29'h2000, 16'd3);
        @(negedge clk);
        check("t2_first_beat", app_wdf_wren, 1'b1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!app_en || app_addr !== 29'h2000 || app_cmd !== CMD_WRITE) bad++;
        end
        check("t2_hold", bad, 0);
        tick(1);
        app_rdy = 1'b1;
        wait_done(1'b0, 50, "t2_done_seen");
        check("t2_ncmd", cmd_q.size(), 3);
        check("t2_pops", pops, 3);
        bad = 0;
        for (int i = 0; i < 3; i++) if (qa(i) !== 29'h2000 + 29'(8 * i)) bad++;
        check("t2_addrs", bad, 0);

        // zero-length write: immediate done, no traffic
        clear_logs();
        push_w(wdat(99));
        start_wr(29'h300, 16'd0);
        @(negedge clk);
        check("zero_done", wr_done, 1'b1);
        check("zero_busy", busy, 1'b0);
        tick(3);
        check("zero_traffic", cmd_q.size() + wdf_q.size(), 0);
        wfifo_q.delete(); wfifo_empty = 1'b1; wfifo_dout = '0;

        // 40-beat read, 10-cycle MIG latency, 16 free FIFO entries
        clear_logs();
        start_rd(29'h4000, 16'd40);
        @(negedge clk);
        check("t3_en_lat", app_en, 1'b1);
        check("t3_cmd", app_cmd, CMD_READ);
        check("t3_addr0", app_addr, 29'h4000);
        wait_done(1'b1, 400, "t3_done_seen");
        check("t3_nrx", rx_q.size(), 40);
        bad = 0;
        for (int i = 0; i < 40; i++) if (i >= rx_q.size() || rx_q[i] !== rdata(29'h4000 + 29'(8 * i))) bad++;
        check("t3_rdata", bad, 0);
        check("t3_max_out_le16", max_out <= 16, 1'b1);
        check("t3_wr_lat", lat_bad, 0);
        check("t3_ncmd", cmd_q.size(), 40);
        check("t3_ndone", rd_dones, 1);
        check("t3_done_lat", rd_done_cyc - last_rx_cyc, 1);
        check("t3_busy_at_done", busy_at_rdone, 1'b1);

        // tight credit, plus a write start while busy
        clear_logs();
        rfifo_free = 10'd4;
        start_rd(29'h5000, 16'd8);
        tick(3);
        wr_base = 29'h0; wr_cnt = 16'd1; start_write = 1'b1;
        tick(1);
        start_write = 1'b0;
        @(negedge clk);
        check("busy_reject", start_reject, 1'b1);
        wait_done(1'b1, 200, "t3b_done_seen");
        check("t3b_max_out", max_out, 4);
        check("t3b_nrx", rx_q.size(), 8);
        check("t3b_nowrite", wdf_q.size(), 0);
        rfifo_free = 10'd16;

        // simultaneous starts: write wins, read rejected
        clear_logs();
        push_w(wdat(20)); push_w(wdat(21));
        tick(1);
        wr_base = 29'h600; wr_cnt = 16'd2; rd_base = 29'h700; rd_cnt = 16'd2;
        start_write = 1'b1; start_read = 1'b1;
        tick(1);
        start_write = 1'b0; start_read = 1'b0;
        @(negedge clk);
        check("t4_reject", start_reject, 1'b1);
        check("t4_busy", busy, 1'b1);
        check("t4_cmd", app_cmd, CMD_WRITE);
        wait_done(1'b0, 50, "t4_done_seen");
        check("t4_ncmd", cmd_q.size(), 2);
        check("t4_addr1", qa(1), 29'h608);
        check("t4_no_rd", rd_dones, 0);
        init_calib_complete = 1'b0;
        start_rd(29'h800, 16'd3);
        @(negedge clk);
        check("t4_calib_reject", start_reject, 1'b1);
        check("t4_calib_busy", busy, 1'b0);
        tick(5);
        check("t4_calib_idle", {busy, 8'(cmd_q.size())}, {1'b0, 8'd2});
        init_calib_complete = 1'b1;

        // address wrap at the top of the space
        clear_logs();
        push_w(wdat(30)); push_w(wdat(31));
        start_wr(29'h1FFF_FFF8, 16'd2);
        wait_done(1'b0, 50, "t5_done_seen");
        check("t5_addr0", qa(0), 29'h1FFF_FFF8);
        check("t5_addr1", qa(1), 29'h0);

        // reset with five reads in flight
        clear_logs();
        rfifo_free = 10'd5;
        start_rd(29'h9000, 16'd20);
        bad = 1;
        for (int t = 0; t < 50 && bad != 0; t++) begin
            @(negedge clk);
            bad = (issued - returned == 5) ? 0 : 1;
        end
        check("t6_out5", issued - returned, 5);
        tick(1);
        sys_rst = 1'b0;
        #1;
        check("t6_rst_outs", {busy, app_en, rfifo_wr_en, rd_done, app_wdf_wren, app_cmd}, '0);
        check("t6_rst_addr", app_addr, '0);
        snap_rx = rx_q.size(); snap_rd = rd_dones;
        tick(2);
        sys_rst = 1'b1;
        snap_ret = returned;
        for (int t = 0; t < 40 && ret_q.size() > 0; t++) tick(1);
        tick(3);
        check("t6_late_returns", returned - snap_ret, 5);
        check("t6_no_wr_en", rx_q.size() - snap_rx, 0);
        check("t6_no_done", rd_dones - snap_rd, 0);
        check("t6_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
